// File: rtl/alu_share_arb.sv
// alu_share_arb: NREQ requesters share one 32-bit ALU through an IDLE/EXEC/RESP handshake FSM.
// Arbitration defaults to round-robin.
// Defining ALU_SHARE_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins) and removes the RR pointer.

// Shared ALU. Opcodes 0..9 are ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; anything else yields 0.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y,
    output logic        zero
);
    // Pure combinational datapath; shift amounts use the low five bits of b.
    always_comb begin
        y = 32'h0;
        case (op)
            4'h0:    y = a + b;
            4'h1:    y = a - b;
            4'h2:    y = a & b;
            4'h3:    y = a | b;
            4'h4:    y = a ^ b;
            4'h5:    y = a << b[4:0];
            4'h6:    y = a >> b[4:0];
            4'h7:    y = $signed(a) >>> b[4:0];
            4'h8:    y = {31'h0, $signed(a) < $signed(b)};
            4'h9:    y = {31'h0, a < b};
            default: y = 32'h0;
        endcase
        zero = (y == 32'h0);
    end
endmodule

module alu_share_arb #(
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][31:0]     req_a,
    input  logic [NREQ-1:0][31:0]     req_b,
    input  logic [NREQ-1:0][3:0]      req_ctrl,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [31:0]               resp_result,
    output logic                      resp_zero,
    output logic [1:0]                grant_id,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
    logic [1:0]  rr_q, rr_d;
`endif

    logic        win_found;
    logic [1:0]  win_idx;
    logic [31:0] win_a, win_b;
    logic [3:0]  win_ctrl;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        resp_fire;

    alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (ctrl_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Winner selection among asserted req_valid; operands are muxed alongside to avoid variable indexing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        win_a     = 32'h0;
        win_b     = 32'h0;
        win_ctrl  = 4'h0;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = 2'(j);
                win_a     = req_a[j];
                win_b     = req_b[j];
                win_ctrl  = req_ctrl[j];
            end
        end
`else
        // First pass covers indices above the last grant, second pass wraps around to 0..last.
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_valid[j] && (2'(j) > rr_q)) begin
                win_found = 1'b1;
                win_idx   = 2'(j);
                win_a     = req_a[j];
                win_b     = req_b[j];
                win_ctrl  = req_ctrl[j];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_valid[j] && (2'(j) <= rr_q)) begin
                win_found = 1'b1;
                win_idx   = 2'(j);
                win_a     = req_a[j];
                win_b     = req_b[j];
                win_ctrl  = req_ctrl[j];
            end
        end
`endif
    end

    // Per-port handshake outputs: ready only to the IDLE winner, valid only to the owner in RESP.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
        assign req_ready[gi]  = (state_q == IDLE) && win_found && (win_idx == 2'(gi));
        assign resp_valid[gi] = (state_q == RESP) && (grant_q == 2'(gi));
    end

    // resp_valid is one-hot on the owner, so this ignores resp_ready from every other port.
    assign resp_fire   = |(resp_valid & resp_ready);
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);

    // Next-state logic for the FSM and its captured operands/results.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        grant_d  = grant_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d     = win_a;
                    b_d     = win_b;
                    ctrl_d  = win_ctrl;
                    grant_d = win_idx;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
                    rr_d    = win_idx;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_y;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            ctrl_q   <= 4'h0;
            grant_q  <= 2'd0;
            result_q <= 32'h0;
            zero_q   <= 1'b0;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            rr_q     <= 2'(NREQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a scoreboard queue of expected responses.
module tb_alu_share_arb;
    localparam int NREQ = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0][3:0]  req_ctrl;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [31:0]           resp_result;
    logic                  resp_zero;
    logic [1:0]            grant_id;
    logic                  busy;

    alu_share_arb #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] result;
        logic        zero;
    } sb_t;

    sb_t sb[$];
    int  cmp_cnt  = 0;
    int  mism_cnt = 0;

    // Reference ALU behaviour.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return 32'($signed(a) >>> b[4:0]);
            4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int p);
        return NREQ'(1) << p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mism_cnt++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        sb_t it;
        it.port   = 2'(port);
        it.result = model(op, a, b);
        it.zero   = (it.result == 32'h0);
        sb.push_back(it);
    endtask

    // Pops the oldest expectation and compares it with the presented response.
    task automatic pop_check(input string tag);
        sb_t it;
        if (sb.size() == 0) begin
            cmp_cnt++;
            mism_cnt++;
            $error("FAIL %s: observed=response expected=empty scoreboard", tag);
        end else begin
            it = sb.pop_front();
            chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(onehot(int'(it.port))));
            chk({tag, "_result"}, resp_result, it.result);
            chk({tag, "_zero"}, 32'(resp_zero), 32'(it.zero));
            chk({tag, "_grant_id"}, 32'(grant_id), 32'(it.port));
            $display("txn %s port=%0d result=0x%08h zero=%0d", tag, grant_id, resp_result, resp_zero);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation from a lone requester; during stall cycles the other port requests and pulses resp_ready.
    task automatic run_op(input string tag, input int port, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int stall);
        int          edges;
        logic [31:0] held;
        @(negedge clk);
        req_valid     = onehot(port);
        req_a         = '0;
        req_b         = '0;
        req_ctrl      = '0;
        req_a[port]   = a;
        req_b[port]   = b;
        req_ctrl[port] = op;
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(onehot(port)));
        push_exp(port, op, a, b);
        @(negedge clk);
        req_valid = '0;
        edges = 1;
        chk({tag, "_busy_exec"}, 32'(busy), 32'd1);
        while (resp_valid == '0 && edges < 6) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd2);
        pop_check(tag);
        held = resp_result;
        for (int s = 0; s < stall; s++) begin
            req_valid  = ~onehot(port);
            resp_ready = ~onehot(port);
            @(negedge clk);
            chk({tag, "_stall_valid"}, 32'(resp_valid), 32'(onehot(port)));
            chk({tag, "_stall_result"}, resp_result, held);
            chk({tag, "_stall_no_grant"}, 32'(req_ready), 32'd0);
        end
        req_valid  = '0;
        resp_ready = onehot(port);
        @(negedge clk);
        resp_ready = '0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    logic [1:0]  rr_exp [4];
    logic [3:0]  v_op   [7];
    logic [31:0] v_a    [7];
    logic [31:0] v_b    [7];

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_zero", 32'(resp_zero), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Port0 ADD 5+7 alone.
        run_op("add0", 0, 4'h0, 32'd5, 32'd7, 0);

        // Both ports valid continuously with SUB 9-9; owner releases each result immediately.
        do_reset();
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
        rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        @(negedge clk);
        req_valid  = '1;
        req_a      = {32'd9, 32'd9};
        req_b      = {32'd9, 32'd9};
        req_ctrl   = {4'h1, 4'h1};
        resp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(onehot(int'(rr_exp[k]))));
            push_exp(int'(rr_exp[k]), 4'h1, 32'd9, 32'd9);
            @(negedge clk);
            @(negedge clk);
            pop_check("rr_sub");
            @(negedge clk);
        end
        req_valid  = '0;
        resp_ready = '0;

        // Port1 SRA with the owner stalling for 5 cycles.
        run_op("sra1", 1, 4'h7, 32'h8000_0000, 32'd4, 5);

        // Reset while Port0 SLT sits in EXEC: no response may appear.
        @(negedge clk);
        req_valid   = 2'b01;
        req_a[0]    = 32'hFFFF_FFFF;
        req_b[0]    = 32'd1;
        req_ctrl[0] = 4'h8;
        #1;
        chk("slt_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("slt_rst_no_resp", 32'(resp_valid), 32'd0);
            chk("slt_rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_op("slt0", 0, 4'h8, 32'hFFFF_FFFF, 32'd1, 0);

        // Illegal opcode, with a non-owner resp_ready pulse during RESP.
        run_op("ill0", 0, 4'hC, 32'd3, 32'd4, 1);

        // A spread of remaining opcodes alternating between ports.
        v_op = '{4'h0, 4'h9, 4'h5, 4'h4, 4'h3, 4'h2, 4'h6};
        v_a  = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'hA5A5_0F0F, 32'h0000_1200, 32'hF0F0_F0F0, 32'h8000_0000};
        v_b  = '{32'd1, 32'hFFFF_FFFF, 32'd31, 32'h5A5A_0F0F, 32'h0034_0000, 32'h0FF0_0FF0, 32'd31};
        for (int k = 0; k < 7; k++) begin
            run_op("mix", k % 2, v_op[k], v_a[k], v_b[k], k % 3);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
